alu_control_unit: RTL and testbench

ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

---
 rtl/alu_control_unit.sv | 96 +++++++++
 tb/tb_alu_control_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// -----------------------------------------------------------------------------
// alu_control_unit
//
// Purpose:
//   Decodes the 5-bit opcode field of a 16-bit instruction word into a one-hot
//   ALU operation select. The select is available combinationally on `out` and
//   as a pipeline-registered copy on `out_q`.
//
//   Select bit meanings:
//     bit0 ADD, bit1 SUB, bit2 AND, bit3 OR, bit4 NOT, bit5 SHR, bit6 SHL.
//   The select is always one-hot or all-zero.
//
// Ports:
//   clk    in   1   rising-edge clock for out_q
//   rst_n  in   1   asynchronous active-low reset, clears out_q
//   inst   in  16   instruction word; opcode = inst[15:11], inst[10:0] unused
//   en     in   1   pipeline enable; out_q holds when low
//   flush  in   1   synchronous clear of out_q, wins over en
//   out    out  7   combinational one-hot ALU select
//   out_q  out  7   out registered on clk
// -----------------------------------------------------------------------------
module alu_control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] inst,
    input  logic        en,
    input  logic        flush,
    output logic [6:0]  out,
    output logic [6:0]  out_q
);

    localparam logic [6:0] SEL_NONE = 7'b000_0000;
    localparam logic [6:0] SEL_ADD  = 7'b000_0001;
    localparam logic [6:0] SEL_SUB  = 7'b000_0010;
    localparam logic [6:0] SEL_AND  = 7'b000_0100;
    localparam logic [6:0] SEL_OR   = 7'b000_1000;
    localparam logic [6:0] SEL_NOT  = 7'b001_0000;
    localparam logic [6:0] SEL_SHR  = 7'b010_0000;
    localparam logic [6:0] SEL_SHL  = 7'b100_0000;

    // Opcode to ALU select. Every opcode that is not a real ALU operation
    // (moves, loads/stores, stack, branches, carry flag ops) still uses the
    // adder for address/increment work, so ADD is the catch-all. Only nop and
    // the unassigned codes produce an all-zero select.
    function automatic logic [6:0] decode_op(input logic [4:0] op);
        logic [6:0] sel;
        case (op)
            5'b10000: sel = SEL_SUB;   // dec
            5'b10001: sel = SEL_SUB;   // sub
            5'b10010: sel = SEL_OR;    // or
            5'b10011: sel = SEL_AND;   // and
            5'b10100: sel = SEL_SHL;   // shl
            5'b10101: sel = SEL_SHR;   // shr
            5'b10110: sel = SEL_NOT;   // not
            5'b11111: sel = SEL_NONE;  // nop
            5'b01010: sel = SEL_NONE;  // unassigned
            5'b01011: sel = SEL_NONE;  // unassigned
            5'b10111: sel = SEL_NONE;  // unassigned
            default:  sel = SEL_ADD;   // all address/flag/branch/move opcodes
        endcase
        return sel;
    endfunction

    logic [6:0] out_d;

    // Operand bits of the instruction play no part in ALU selection.
    logic unused_operand_s;
    assign unused_operand_s = ^inst[10:0];

    // Combinational decode of the opcode field.
    always_comb begin
        out = decode_op(inst[15:11]);
    end

    // Next value of the pipeline register: flush beats enable beats hold.
    always_comb begin
        out_d = out_q;
        if (flush) begin
            out_d = SEL_NONE;
        end else if (en) begin
            out_d = out;
        end else begin
            out_d = out_q;
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= SEL_NONE;
        end else begin
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_alu_control_unit.sv
module tb_alu_control_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] inst;
    logic        en;
    logic        flush;
    logic [6:0]  out;
    logic [6:0]  out_q;

    int tests_run;
    int tests_failed;

    // Hand-written expected select for each opcode 0..31.
    logic [6:0] exp_tab [32];

    alu_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .inst  (inst),
        .en    (en),
        .flush (flush),
        .out   (out),
        .out_q (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  op;
        logic [6:0]  held;
        tests_run    = 0;
        tests_failed = 0;

        exp_tab = '{
            7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001,  // 00-03
            7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001,  // 04-07
            7'b0000001, 7'b0000001, 7'b0000000, 7'b0000000,  // 08-0B
            7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001,  // 0C-0F
            7'b0000010, 7'b0000010, 7'b0001000, 7'b0000100,  // 10-13
            7'b1000000, 7'b0100000, 7'b0010000, 7'b0000000,  // 14-17
            7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001,  // 18-1B
            7'b0000001, 7'b0000001, 7'b0000001, 7'b0000000   // 1C-1F
        };

        // Reset held with en/flush active: out_q stays zero, out still decodes.
        rst_n = 1'b0;
        en    = 1'b1;
        flush = 1'b0;
        inst  = 16'h9000;
        #2;
        check("reset_out_q", out_q, 7'b0000000);
        check("reset_out_follows", out, 7'b0001000);
        tick();
        tick();
        check("reset_hold_en", out_q, 7'b0000000);
        flush = 1'b1;
        tick();
        check("reset_hold_flush", out_q, 7'b0000000);
        flush = 1'b0;

        // Release between edges with en low: no load until enabled.
        en = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("post_reset_en0", out_q, 7'b0000000);

        // Opcode sweep with operand bits all-zero then all-ones.
        for (int i = 0; i < 32; i++) begin
            op   = 5'(i);
            inst = {op, 11'h000};
            #1;
            check($sformatf("sweep_lo_op%0d", i), out, exp_tab[i]);
            inst = {op, 11'h7FF};
            #1;
            check($sformatf("sweep_hi_op%0d", i), out, exp_tab[i]);
        end

        // Directed spot checks.
        inst = 16'hF800; #1; check("spot_F800", out, 7'b0000000);
        inst = 16'h9000; #1; check("spot_9000", out, 7'b0001000);
        inst = 16'h9800; #1; check("spot_9800", out, 7'b0000100);
        inst = 16'hA000; #1; check("spot_A000", out, 7'b1000000);
        inst = 16'hA800; #1; check("spot_A800", out, 7'b0100000);
        inst = 16'hB000; #1; check("spot_B000", out, 7'b0010000);
        inst = 16'h8800; #1; check("spot_8800", out, 7'b0000010);

        // Registered path with en=1.
        en   = 1'b1;
        inst = 16'h9000;
        tick();
        check("reg_9000", out_q, 7'b0001000);
        inst = 16'hA000;
        #2;
        check("reg_before_edge", out_q, 7'b0001000);
        tick();
        check("reg_A000", out_q, 7'b1000000);

        // Hold for three clocks with en=0 while inst changes.
        en = 1'b0;
        inst = 16'h8800; tick(); check("hold_1", out_q, 7'b1000000);
        inst = 16'h9800; tick(); check("hold_2", out_q, 7'b1000000);
        inst = 16'hB000; tick(); check("hold_3", out_q, 7'b1000000);

        // Flush with en=1 clears even though out is non-zero.
        en    = 1'b1;
        flush = 1'b1;
        inst  = 16'hA800;
        tick();
        check("flush_en1", out_q, 7'b0000000);
        flush = 1'b0;
        tick();
        check("load_after_flush", out_q, 7'b0100000);

        // Flush with en=0 also clears.
        en    = 1'b0;
        flush = 1'b1;
        tick();
        check("flush_en0", out_q, 7'b0000000);
        flush = 1'b0;

        // Asynchronous reset mid-cycle overrides a pending capture.
        en   = 1'b1;
        inst = 16'hA000;
        tick();
        check("pre_async", out_q, 7'b1000000);
        inst = 16'h9000;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", out_q, 7'b0000000);
        tick();
        check("async_hold", out_q, 7'b0000000);
        #2;
        rst_n = 1'b1;
        tick();
        check("async_release_load", out_q, 7'b0001000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
